adder_rr_arbiter: RTL and testbench

//   Shares one 8-bit adder datapath (sum = a + b) between NUM_REQ requesters.

---
 rtl/adder_arb_pkg.sv | 21 ++
 rtl/adder_rr_arbiter_rr_pick.sv | 51 +++++
 rtl/adder_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_adder_rr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Package: adder_arb_pkg
// Purpose : Shared types and helpers for the round-robin adder arbiter.
//   out_state_e : state of the one-entry result stage (empty / holding a result)
//   id_width(n) : width of a requester index, never less than one bit
//   rr_next(i,n): round-robin successor of index i among n requesters (wraps to 0)
package adder_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic int id_width(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 32'sd1) ? 32'sd0 : idx + 32'sd1;
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Module : rr_pick
// Purpose: Combinational round-robin picker. Scans the valid vector starting at
//          rr_ptr and wrapping, and reports the first requester found.
// Ports  :
//   valid  in  NUM_REQ  request vector
//   rr_ptr in  IDW      index that has highest priority this cycle
//   grant  out NUM_REQ  one-hot of the picked index (all zero when nothing valid)
//   idx    out IDW      binary index of the picked requester
//   any    out 1        at least one requester is valid
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [IDW:0]         off_s;
    logic [IDW:0]         sum_s;

    // Rotating a doubled copy puts rr_ptr at bit 0, so a plain lowest-bit
    // search becomes the round-robin scan.
    assign dbl_s = {valid, valid};
    assign rot_s = NUM_REQ'(dbl_s >> rr_ptr);
    assign any   = |valid;

    // Lowest set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        off_s = {(IDW+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? (IDW+1)'(k) : off_s;
        end
        sum_s = {1'b0, rr_ptr} + off_s;
        if (sum_s >= (IDW+1)'(NUM_REQ)) begin
            idx = IDW'(sum_s - (IDW+1)'(NUM_REQ));
        end else begin
            idx = IDW'(sum_s);
        end
        if (any) begin
            grant = NUM_REQ'(1'b1) << idx;
        end else begin
            grant = {NUM_REQ{1'b0}};
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Module : adder_rr_arbiter
// Purpose: One 8-bit adder shared by NUM_REQ requesters through a round-robin
//          arbiter, with a one-entry registered result stage tagged with the
//          index of the requester that produced it.
// Ports  :
//   clk, rst             clock; synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot grant)
//   req_a, req_b         packed operands, slice i = [i*WIDTH +: WIDTH]
//   res_valid/res_ready  result handshake
//   res_sum, res_carry   (a+b) mod 2^WIDTH and its carry-out
//   res_id               index of the requester that produced the result
//   stall_cnt            (only with ADDER_ARB_STATS_EN) saturating count of
//                        cycles with some request pending but no grant
// Build option: define ADDER_ARB_STATS_EN to add the stall_cnt port and counter.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_carry,
    output logic [IDW-1:0]           res_id
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    out_state_e         state_r;
    logic [IDW-1:0]     rr_ptr_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic [IDW-1:0]     id_r;

    logic [NUM_REQ-1:0] pick_grant_s;
    logic [IDW-1:0]     pick_idx_s;
    logic               pick_any_s;
    logic               can_accept_s;
    logic               grant_fire_s;
    logic [WIDTH-1:0]   a_sel_s;
    logic [WIDTH-1:0]   b_sel_s;
    logic [WIDTH:0]     add_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .valid   (req_valid),
        .rr_ptr  (rr_ptr_r),
        .grant   (pick_grant_s),
        .idx     (pick_idx_s),
        .any     (pick_any_s)
    );

    // A full stage can take a new result in the same edge it is drained, which
    // is why res_ready feeds req_ready combinationally.
    assign can_accept_s = ~rst & ((state_r == ST_EMPTY) | res_ready);
    assign grant_fire_s = can_accept_s & pick_any_s;
    assign req_ready    = grant_fire_s ? pick_grant_s : {NUM_REQ{1'b0}};

    assign res_valid = (state_r == ST_FULL);
    assign res_sum   = sum_r;
    assign res_carry = carry_r;
    assign res_id    = id_r;

    // Operand mux for the picked requester, then the shared adder.
    always_comb begin
        a_sel_s = {WIDTH{1'b0}};
        b_sel_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            a_sel_s = (pick_idx_s == IDW'(i)) ? req_a[i*WIDTH +: WIDTH] : a_sel_s;
            b_sel_s = (pick_idx_s == IDW'(i)) ? req_b[i*WIDTH +: WIDTH] : b_sel_s;
        end
        add_s = {1'b0, a_sel_s} + {1'b0, b_sel_s};
    end

    // Result-stage FSM, result register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_EMPTY;
            rr_ptr_r <= {IDW{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            id_r     <= {IDW{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: state_r <= grant_fire_s ? ST_FULL : ST_EMPTY;
                ST_FULL:  state_r <= (grant_fire_s || !res_ready) ? ST_FULL : ST_EMPTY;
                default:  state_r <= ST_EMPTY;
            endcase
            if (grant_fire_s) begin
                {carry_r, sum_r} <= add_s;
                id_r             <= pick_idx_s;
                rr_ptr_r         <= IDW'(rr_next(int'(pick_idx_s), NUM_REQ));
            end
        end
    end

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles where a request waits without being granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if ((|req_valid) && !grant_fire_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Testbench for adder_rr_arbiter (NUM_REQ=4, WIDTH=8). A behavioural model of
// the arbiter (pointer, held result) predicts outputs every cycle; directed
// phases add literal expectations, followed by a randomized phase.
module tb_adder_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_sum;
    logic        res_carry;
    logic [1:0]  res_id;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model state
    bit m_known = 1'b0;
    bit m_valid = 1'b0;
    int m_sum   = 0;
    int m_carry = 0;
    int m_id    = 0;
    int m_ptr   = 0;
    int m_stall = 0;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id)
`ifdef ADDER_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which requester the arbiter must grant right now, or -1 for none.
    function automatic int model_pick();
        int i;
        if (rst) return -1;
        if (m_valid && !res_ready) return -1;
        for (int k = 0; k < 4; k++) begin
            i = (m_ptr + k) % 4;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    // One clock: compare DUT with model, take the edge, advance the model.
    task automatic cycle();
        int g;
        int t;
        logic [3:0] exp_rdy;
        #1;
        g = model_pick();
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        if (rst || m_known) chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (m_known) begin
            chk("res_valid", 32'(res_valid), 32'(m_valid));
            chk("res_sum",   32'(res_sum),   32'(m_sum));
            chk("res_carry", 32'(res_carry), 32'(m_carry));
            chk("res_id",    32'(res_id),    32'(m_id));
`ifdef ADDER_ARB_STATS_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        end
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_sum   = 0;
            m_carry = 0;
            m_id    = 0;
            m_ptr   = 0;
            m_stall = 0;
        end else begin
            if ((req_valid != 4'b0000) && (g < 0) && (m_stall < 65535)) m_stall++;
            if (g >= 0) begin
                t       = int'(req_a[g*8 +: 8]) + int'(req_b[g*8 +: 8]);
                m_sum   = t % 256;
                m_carry = t / 256;
                m_id    = g;
                m_ptr   = (g + 1) % 4;
                m_valid = 1'b1;
            end else if (res_ready) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // reset with every requester asking
        rst       = 1'b1;
        req_valid = 4'hF;
        res_ready = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        cycle();
        cycle();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(res_valid), 32'h0);
        chk("rst_sum",   32'(res_sum),   32'h0);
        chk("rst_id",    32'(res_id),    32'h0);

        // single request from requester 0
        rst         = 1'b0;
        req_valid   = 4'b0001;
        req_a[7:0]  = 8'h12;
        req_b[7:0]  = 8'h34;
        res_ready   = 1'b1;
        #1 chk("single_ready", 32'(req_ready), 32'h1);
        cycle();
        chk("single_valid", 32'(res_valid), 32'h1);
        chk("single_sum",   32'(res_sum),   32'h46);
        chk("single_carry", 32'(res_carry), 32'h0);
        chk("single_id",    32'(res_id),    32'h0);

        // overflow
        req_a[7:0] = 8'hFF;
        req_b[7:0] = 8'h02;
        cycle();
        chk("ovf_sum",   32'(res_sum),   32'h01);
        chk("ovf_carry", 32'(res_carry), 32'h1);

        // return pointer to 0 before the round-robin sweep
        rst       = 1'b1;
        req_valid = 4'b0000;
        cycle();
        rst = 1'b0;

        // round robin with everyone asking
        req_valid = 4'hF;
        req_a     = $urandom;
        req_b     = $urandom;
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_grant", 32'(req_ready), 32'(rr_exp[k]));
            cycle();
            chk("rr_id", 32'(res_id), 32'(k % 4));
        end

        // back-pressure: result held, no grants
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_ready", 32'(req_ready), 32'h0);
            cycle();
            chk("bp_valid", 32'(res_valid), 32'h1);
            chk("bp_id",    32'(res_id),    32'h0);
        end
        res_ready = 1'b1;
        #1 chk("drain_grant", 32'(req_ready), 32'h2);
        cycle();
        chk("drain_valid", 32'(res_valid), 32'h1);
        chk("drain_id",    32'(res_id),    32'h1);
        res_ready = 1'b0;

        // reset while holding a result, then stalls
        rst = 1'b1;
        cycle();
        chk("midrst_valid", 32'(res_valid), 32'h0);
        rst       = 1'b0;
        req_valid = 4'hF;
        #1 chk("midrst_grant", 32'(req_ready), 32'h1);
        cycle();
        for (int k = 0; k < 5; k++) cycle();
        chk("stall_id", 32'(res_id), 32'h0);
`ifdef ADDER_ARB_STATS_EN
        chk("stall_cnt5", 32'(stall_cnt), 32'd5);
`endif

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            req_valid = 4'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            req_a     = $urandom;
            req_b     = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
